// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port RAM arbiter between instruction fetch and MEM stage with starvation guard and access timeout
module mem_port_arbiter #(
  parameter int TIMEOUT    = 15,
  parameter int MAX_STARVE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        stall_fetch,
  output logic        stall_pipe,
  output logic        err_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(MAX_STARVE + 2);
  typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic gnt_if, acc, expire, if_win, grant;
  always_comb begin
    acc         = state == IF_ACC || state == MEM_ACC;
    expire      = acc && !ram_ack && cnt == CW'(TIMEOUT - 1);
    if_win      = if_req && (!mem_req || starve == SW'(MAX_STARVE));
    grant       = state == IDLE && (if_req || mem_req);
    state_nxt   = state == IDLE ? (if_win ? IF_ACC : mem_req ? MEM_ACC : IDLE) :
                  acc ? ((ram_ack || expire) ? DONE : state) : IDLE;
    ram_en      = acc;
    if_ready    = state == DONE && gnt_if;
    mem_ready   = state == DONE && !gnt_if;
    // stalls are gated by reset so every output reads 0 while rst_n is low
    stall_pipe  = rst_n && mem_req && !mem_ready;
    stall_fetch = (rst_n && if_req && !if_ready) || stall_pipe;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      starve      <= '0;
      gnt_if      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= acc ? cnt + 1'b1 : '0;
      if (grant) begin
        gnt_if    <= if_win;
        ram_addr  <= if_win ? if_addr : mem_addr;
        ram_we    <= !if_win && mem_we;
        ram_wdata <= if_win ? '0 : mem_wdata;
        starve    <= if_win ? '0 : (if_req && starve != SW'(MAX_STARVE)) ? starve + 1'b1 : starve;
      end
      // an ack on the final cycle takes priority over the timeout abort
      if (acc && (ram_ack || expire)) begin
        if (gnt_if) if_rdata <= ram_ack ? ram_rdata : '0;
        else mem_rdata <= ram_ack ? ram_rdata : '0;
      end
      if (expire) err_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus corner sequences, RAM responder and ready-pulse scoreboard
module tb_mem_port_arbiter;
  logic clk, rst_n;
  logic if_req, mem_req, mem_we, ram_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic if_ready, mem_ready, ram_en, ram_we, stall_fetch, stall_pipe, err_timeout;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .stall_fetch(stall_fetch), .stall_pipe(stall_pipe), .err_timeout(err_timeout)
  );

  typedef struct {
    bit ri, rm, we;
    logic [31:0] ia, ma, wd;
    int lat;
    bit mem_first;
  } vec_t;
  typedef struct {
    bit is_if, we;
    logic [31:0] data, addr, wd;
    int run;
  } exp_t;

  int checks = 0, errors = 0;
  int lat = 1;
  int run = 0;
  bit in_run = 0, unstable = 0, run_we = 0;
  logic [31:0] run_addr = 0, run_wd = 0;
  exp_t sbq[$];

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a == 32'h40 ? 32'h00A00093 : {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_if, input logic [31:0] a, input bit we, input logic [31:0] wd);
    exp_t e;
    e.is_if = is_if;
    e.addr  = a;
    e.we    = we;
    e.wd    = wd;
    e.data  = lat == 0 ? 32'h0 : rd(a);
    e.run   = lat == 0 ? 15 : lat;
    sbq.push_back(e);
  endtask

  // RAM responder and scoreboard monitor, both working on the falling edge
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (ram_en) begin
      if (!in_run) begin
        run = 0; run_we = ram_we; run_addr = ram_addr; run_wd = ram_wdata; unstable = 0;
      end
      in_run = 1;
      run++;
      if (ram_we !== run_we || ram_addr !== run_addr || ram_wdata !== run_wd) unstable = 1;
      ram_ack = lat != 0 && run == lat;
      ram_rdata = rd(ram_addr);
    end else begin
      in_run = 0;
      ram_ack = 0;
    end
    if (if_ready || mem_ready) begin
      if (sbq.size() == 0) chk("unexpected_ready", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("winner_is_if", {31'b0, if_ready}, {31'b0, e.is_if});
        chk("rdata", e.is_if ? if_rdata : mem_rdata, e.data);
        chk("en_run_len", 32'(run), 32'(e.run));
        chk("ram_we", {31'b0, run_we}, {31'b0, e.we});
        chk("ram_addr", run_addr, e.addr);
        if (e.we) chk("ram_wdata", run_wd, e.wd);
        chk("ram_stable", {31'b0, unstable}, 0);
      end
    end
  end

  task automatic run_reqs(input bit ri, input bit rm, input bit we, input logic [31:0] ia,
                          input logic [31:0] ma, input logic [31:0] wd, input int mem_n);
    int mleft, guard, bad;
    bit pend_if;
    mleft = rm ? mem_n : 0;
    pend_if = ri;
    guard = 0;
    bad = 0;
    if_addr = ia; mem_addr = ma; mem_we = we; mem_wdata = wd;
    if_req = ri; mem_req = rm;
    while ((pend_if || mleft > 0) && guard < 400) begin
      @(negedge clk);
      guard++;
      if (stall_pipe !== (mem_req & ~mem_ready)) bad++;
      if (stall_fetch !== ((if_req & ~if_ready) | (mem_req & ~mem_ready))) bad++;
      if (if_ready) begin pend_if = 0; if_req = 0; end
      if (mem_ready && mleft > 0) begin
        mleft--;
        if (mleft == 0) mem_req = 0;
      end
    end
    chk("completed_in_budget", {31'b0, pend_if || mleft > 0}, 0);
    chk("stall_outputs", 32'(bad), 0);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 0);
  endtask

  initial begin
    vec_t vecs[7];
    bit err_exp;
    int bound, rdy_cnt;
    bit en_pat[5], rdy_pat[5];
    vecs[0] = '{ri:1, rm:0, we:0, ia:32'h40,  ma:32'h0,   wd:32'h0,        lat:2, mem_first:0};
    vecs[1] = '{ri:0, rm:1, we:0, ia:32'h0,   ma:32'h80,  wd:32'h0,        lat:1, mem_first:1};
    vecs[2] = '{ri:1, rm:1, we:1, ia:32'h44,  ma:32'h100, wd:32'hDEADBEEF, lat:1, mem_first:1};
    vecs[3] = '{ri:0, rm:1, we:1, ia:32'h0,   ma:32'h104, wd:32'h12345678, lat:3, mem_first:1};
    vecs[4] = '{ri:1, rm:1, we:0, ia:32'h48,  ma:32'h108, wd:32'h0,        lat:4, mem_first:1};
    vecs[5] = '{ri:1, rm:0, we:0, ia:32'h4C,  ma:32'h0,   wd:32'h0,        lat:5, mem_first:0};
    vecs[6] = '{ri:0, rm:1, we:0, ia:32'h0,   ma:32'h10C, wd:32'h0,        lat:0, mem_first:1};
    rst_n = 0; if_req = 0; mem_req = 0; mem_we = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; ram_ack = 0; ram_rdata = 0;
    #1;
    chk("rst_outputs", {if_rdata | mem_rdata | ram_addr | ram_wdata},  0);
    chk("rst_flags", {25'b0, if_ready, mem_ready, ram_en, ram_we, stall_fetch, stall_pipe, err_timeout}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    err_exp = 0;
    foreach (vecs[i]) begin
      lat = vecs[i].lat;
      if (vecs[i].ri && vecs[i].rm && !vecs[i].mem_first) push(1, vecs[i].ia, 0, 0);
      if (vecs[i].rm) push(0, vecs[i].ma, vecs[i].we, vecs[i].wd);
      if (vecs[i].ri && (!vecs[i].rm || vecs[i].mem_first)) push(1, vecs[i].ia, 0, 0);
      run_reqs(vecs[i].ri, vecs[i].rm, vecs[i].we, vecs[i].ia, vecs[i].ma, vecs[i].wd, 1);
      err_exp |= vecs[i].lat == 0;
      chk("err_timeout", {31'b0, err_timeout}, {31'b0, err_exp});
    end
    repeat (5) @(negedge clk);
    chk("err_timeout_sticky", {31'b0, err_timeout}, 1);

    // reset one cycle into a store access: everything drops at once, no ready afterwards
    lat = 0;
    mem_addr = 32'h130; mem_wdata = 32'hCAFEF00D; mem_we = 1; mem_req = 1;
    bound = 0;
    while (!ram_en && bound < 20) begin @(negedge clk); bound++; end
    chk("reset_test_en_seen", {31'b0, ram_en}, 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_ram_en", {31'b0, ram_en}, 0);
    chk("async_rst_data", {if_rdata | mem_rdata | ram_addr | ram_wdata}, 0);
    chk("async_rst_flags", {25'b0, if_ready, mem_ready, ram_en, ram_we, stall_fetch, stall_pipe, err_timeout}, 0);
    mem_req = 0; mem_we = 0;
    @(negedge clk);
    rst_n = 1;
    rdy_cnt = 0;
    repeat (20) begin @(negedge clk); rdy_cnt += int'(mem_ready); end
    chk("no_ready_after_reset", 32'(rdy_cnt), 0);

    // ack on the final allowed cycle is a success
    lat = 15;
    push(0, 32'h110, 0, 0);
    run_reqs(0, 1, 0, 0, 32'h110, 0, 1);
    chk("ack_at_limit_no_err", {31'b0, err_timeout}, 0);

    // minimum latency with back-to-back loads
    lat = 1;
    repeat (2) @(negedge clk);
    push(0, 32'h120, 0, 0);
    push(0, 32'h120, 0, 0);
    en_pat  = '{1, 0, 0, 1, 0};
    rdy_pat = '{0, 1, 0, 0, 1};
    mem_addr = 32'h120; mem_we = 0; mem_req = 1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lat_ram_en", {31'b0, ram_en}, {31'b0, en_pat[k]});
      chk("lat_mem_ready", {31'b0, mem_ready}, {31'b0, rdy_pat[k]});
    end
    mem_req = 0;
    #1;
    chk("lat_scoreboard_drained", 32'(sbq.size()), 0);

    // starvation: fetch wins the fourth arbitration after three losses
    repeat (2) @(negedge clk);
    push(0, 32'h200, 0, 0);
    push(0, 32'h200, 0, 0);
    push(0, 32'h200, 0, 0);
    push(1, 32'h300, 0, 0);
    push(0, 32'h200, 0, 0);
    run_reqs(1, 1, 0, 32'h300, 32'h200, 0, 4);
    chk("final_err_clear", {31'b0, err_timeout}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
